quant_err_acc: RTL and testbench

- Downstream neighbour of the bit-switch stage in the wordlength-optimisation datapath.
- Per sample, takes the full-precision value and its masked (quantised) counterpart and computes the absolute quantisation error.
- Accumulates that error over a programmed number of samples and also tracks the peak error.
- The WLO controller reads the sum and peak to score one (num_int, num_frac) candidate.

---
 rtl/wlo_pkg.sv | 41 ++++
 rtl/qerr_diff.sv | 44 ++++
 rtl/quant_err_acc.sv | 170 +++++++++++++++++
 tb/tb_quant_err_acc.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wlo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wlo_pkg
// Description : Shared types and helpers for the wordlength-optimisation
//               datapath (quant_err_acc state encoding, widths, saturation).
// Revision    : 1.0 - initial release
// ============================================================================
package wlo_pkg;

    typedef enum logic [1:0] {
        QERR_IDLE  = 2'd0,
        QERR_RUN   = 2'd1,
        QERR_DRAIN = 2'd2,
        QERR_DONE  = 2'd3
    } qerr_state_t;

    // Widest accumulator the saturating helper can serve.
    localparam int c_sat_max_w = 128;

    function automatic int diff_w(input int max_len);
        return max_len + 1;
    endfunction

    // Returns {saturated, result}; result clamps at 2^width-1.
    function automatic logic [c_sat_max_w:0] sat_add(
        input logic [c_sat_max_w-1:0] acc,
        input logic [c_sat_max_w-1:0] inc,
        input int unsigned            width
    );
        logic [c_sat_max_w:0] sum;
        logic [c_sat_max_w:0] cap;
        sum = {1'b0, acc} + {1'b0, inc};
        cap = ({{c_sat_max_w{1'b0}}, 1'b1} << width) - 1'b1;
        if (sum > cap) begin
            return {1'b1, cap[c_sat_max_w-1:0]};
        end
        return {1'b0, sum[c_sat_max_w-1:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/qerr_diff.sv
`default_nettype none
// ============================================================================
// Module      : qerr_diff
// Description : Registered signed difference of reference and quantised sample
//               with a valid bit; presents the exact absolute error.
// Revision    : 1.0 - initial release
// ============================================================================
module qerr_diff
    import wlo_pkg::*;
#(
    parameter int MAX_LEN = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_fire,
    input  logic [MAX_LEN-1:0]          i_ref,
    input  logic [MAX_LEN-1:0]          i_qnt,
    output logic                        o_abs_valid,
    output logic [diff_w(MAX_LEN)-1:0]  o_abs
);

    localparam int c_w = diff_w(MAX_LEN);

    logic [c_w-1:0] r_diff;
    logic           r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_diff  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_fire;
            if (i_fire) begin
                r_diff <= {i_ref[MAX_LEN-1], i_ref} - {i_qnt[MAX_LEN-1], i_qnt};
            end
        end
    end

    // One guard bit means the most-negative value never occurs, so negation is exact.
    assign o_abs       = r_diff[c_w-1] ? ('0 - r_diff) : r_diff;
    assign o_abs_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/quant_err_acc.sv
`default_nettype none
// ============================================================================
// Module      : quant_err_acc
// Description : Accumulates |ref - qnt| (or its square with QERR_SQUARE_EN)
//               over a programmed run and tracks the peak error.
// Revision    : 1.0 - initial release
// ============================================================================
module quant_err_acc
    import wlo_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int INT_POS = 16,
    parameter int CNT_W   = 16,
    parameter int ACC_W   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_samples,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MAX_LEN-1:0]   ref_i,
    input  logic [MAX_LEN-1:0]   qnt_i,
    output logic                 busy,
    output logic                 done,
    output logic [ACC_W-1:0]     err_sum,
    output logic [MAX_LEN:0]     err_max,
    output logic                 overflow
);

    localparam int c_diff_w = diff_w(MAX_LEN);

    generate
        if (ACC_W < c_diff_w || ACC_W >= c_sat_max_w) begin : g_bad_acc_w
            $error("quant_err_acc: ACC_W out of supported range");
        end
        if (INT_POS < 0 || INT_POS > MAX_LEN) begin : g_bad_int_pos
            $error("quant_err_acc: INT_POS outside the data word");
        end
`ifdef QERR_SQUARE_EN
        if (ACC_W < 2 * c_diff_w) begin : g_bad_sq_acc_w
            $error("quant_err_acc: ACC_W too narrow for squared error");
        end
`endif
    endgenerate

    qerr_state_t            r_state;
    qerr_state_t            w_state_nxt;
    logic [CNT_W-1:0]       r_count;
    logic [ACC_W-1:0]       r_err_sum;
    logic [c_diff_w-1:0]    r_err_max;
    logic                   r_overflow;

    logic                   w_fire;
    logic                   w_start_ok;
    logic                   w_abs_valid;
    logic [c_diff_w-1:0]    w_abs;
    logic                   w_pipe_busy;
    logic                   w_acc_valid;
    logic [c_sat_max_w-1:0] w_acc_inc;
    logic [c_sat_max_w:0]   w_sat;
    logic                   w_unused_sat_hi;

    assign in_ready   = (r_state == QERR_RUN) && (r_count != '0);
    assign w_fire     = in_valid && in_ready;
    assign w_start_ok = start && ((r_state == QERR_IDLE) || (r_state == QERR_DONE));

    qerr_diff #(
        .MAX_LEN (MAX_LEN)
    ) u_diff (
        .clk         (clk),
        .rst         (rst),
        .i_fire      (w_fire),
        .i_ref       (ref_i),
        .i_qnt       (qnt_i),
        .o_abs_valid (w_abs_valid),
        .o_abs       (w_abs)
    );

`ifdef QERR_SQUARE_EN
    logic [2*c_diff_w-1:0] r_sq;
    logic                  r_sq_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sq       <= '0;
            r_sq_valid <= 1'b0;
        end else begin
            r_sq_valid <= w_abs_valid;
            if (w_abs_valid) begin
                r_sq <= {{c_diff_w{1'b0}}, w_abs} * {{c_diff_w{1'b0}}, w_abs};
            end
        end
    end

    assign w_pipe_busy = w_abs_valid || r_sq_valid;
    assign w_acc_valid = r_sq_valid;
    assign w_acc_inc   = {{(c_sat_max_w-2*c_diff_w){1'b0}}, r_sq};
`else
    assign w_pipe_busy = w_abs_valid;
    assign w_acc_valid = w_abs_valid;
    assign w_acc_inc   = {{(c_sat_max_w-c_diff_w){1'b0}}, w_abs};
`endif

    assign w_sat           = sat_add({{(c_sat_max_w-ACC_W){1'b0}}, r_err_sum}, w_acc_inc,
                                     unsigned'(ACC_W));
    assign w_unused_sat_hi = ^w_sat[c_sat_max_w-1:ACC_W];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            QERR_IDLE, QERR_DONE: begin
                if (start) begin
                    w_state_nxt = (num_samples != '0) ? QERR_RUN : QERR_DONE;
                end
            end
            QERR_RUN: begin
                if (w_fire && (r_count == CNT_W'(1))) begin
                    w_state_nxt = QERR_DRAIN;
                end
            end
            QERR_DRAIN: begin
                if (!w_pipe_busy) begin
                    w_state_nxt = QERR_DONE;
                end
            end
            default: w_state_nxt = QERR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= QERR_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                r_count <= num_samples;
            end else if (w_fire) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_err_sum  <= '0;
            r_err_max  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_acc_valid) begin
                r_err_sum <= w_sat[ACC_W-1:0];
                if (w_sat[c_sat_max_w]) begin
                    r_overflow <= 1'b1;
                end
            end
            if (w_abs_valid && (w_abs > r_err_max)) begin
                r_err_max <= w_abs;
            end
        end
    end

    assign busy     = (r_state == QERR_RUN) || (r_state == QERR_DRAIN);
    assign done     = (r_state == QERR_DONE);
    assign err_sum  = r_err_sum;
    assign err_max  = r_err_max;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_quant_err_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_quant_err_acc
// Description : Randomised self-checking bench for quant_err_acc (ACC_W=33).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quant_err_acc;

    localparam int MAX_LEN = 32;
    localparam int CNT_W   = 16;
    localparam int ACC_W   = 33;
    localparam longint unsigned SUM_CAP = (64'd1 << ACC_W) - 64'd1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [CNT_W-1:0]   num_samples = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [MAX_LEN-1:0] ref_i = '0;
    logic [MAX_LEN-1:0] qnt_i = '0;
    logic               busy;
    logic               done;
    logic [ACC_W-1:0]   err_sum;
    logic [MAX_LEN:0]   err_max;
    logic               overflow;

    int vectors    = 0;
    int miscompares = 0;

    logic [MAX_LEN-1:0] stim_ref[$];
    logic [MAX_LEN-1:0] stim_qnt[$];
    longint unsigned    exp_sum;
    longint unsigned    exp_max;
    bit                 exp_ovf;

    always #5 clk = ~clk;

    quant_err_acc #(
        .MAX_LEN (MAX_LEN),
        .INT_POS (16),
        .CNT_W   (CNT_W),
        .ACC_W   (ACC_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_samples (num_samples),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ref_i       (ref_i),
        .qnt_i       (qnt_i),
        .busy        (busy),
        .done        (done),
        .err_sum     (err_sum),
        .err_max     (err_max),
        .overflow    (overflow)
    );

    // Reference: L1 error summed with a saturating cap, peak tracked separately.
    function automatic void model(input int n);
        longint          d;
        longint unsigned a;
        exp_sum = 0;
        exp_max = 0;
        exp_ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            d = longint'($signed(stim_ref[i])) - longint'($signed(stim_qnt[i]));
            a = (d < 0) ? longint'(-d) : longint'(d);
            if (exp_sum + a > SUM_CAP) begin
                exp_sum = SUM_CAP;
                exp_ovf = 1'b1;
            end else begin
                exp_sum = exp_sum + a;
            end
            if (a > exp_max) exp_max = a;
        end
    endfunction

    task automatic load_const(input int n, input logic [31:0] r, input logic [31:0] q);
        stim_ref.delete();
        stim_qnt.delete();
        for (int i = 0; i < n; i++) begin
            stim_ref.push_back(r);
            stim_qnt.push_back(q);
        end
    endtask

    // gap: 0 = back-to-back, 1 = toggle every cycle, 2 = random. lat counts
    // negedges from the one following the last accept until done is seen.
    task automatic do_run(input int n, input int gap, input bit stray,
                          output int lat, output bit rdy_after);
        int idx;
        int guard;
        bit fire;
        bit tog;
        @(negedge clk);
        start       = 1'b1;
        num_samples = CNT_W'(n);
        @(negedge clk);
        start       = 1'b0;
        num_samples = CNT_W'($urandom);
        idx = 0;
        guard = 0;
        tog = 1'b0;
        while (idx < n && guard < 2000) begin
            guard++;
            case (gap)
                0:       in_valid = 1'b1;
                1:       begin in_valid = tog; tog = ~tog; end
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            if (in_valid) begin
                ref_i = stim_ref[idx];
                qnt_i = stim_qnt[idx];
            end else begin
                ref_i = $urandom;
                qnt_i = $urandom;
            end
            start = stray && (idx == 1);
            if (start) num_samples = CNT_W'(99);
            fire = in_valid && in_ready;
            @(negedge clk);
            if (fire) idx++;
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        rdy_after = in_ready;
        vectors++;
        if (idx !== n) begin
            miscompares++;
            $display("FAIL feed_timeout accepted=%0d required=%0d", idx, n);
        end
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        int lat;
        bit rdy;
        load_const(8, 32'h0004_0000, 32'h0000_0000);
        @(negedge clk);
        start = 1'b1;
        num_samples = CNT_W'(8);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        ref_i = 32'h0004_0000;
        qnt_i = 32'h0000_0000;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, done, in_ready, overflow} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags got busy/done/rdy/ovf=%b%b%b%b want 0000",
                     busy, done, in_ready, overflow);
        end
        vectors++;
        if (err_sum !== '0 || err_max !== '0) begin
            miscompares++;
            $display("FAIL reset_results got sum=%0h max=%0h want 0/0", err_sum, err_max);
        end
        // The discarded run must not leak into a fresh one.
        do_run(1, 0, 1'b0, lat, rdy);
        model(1);
        vectors++;
        if (64'(err_sum) !== exp_sum) begin
            miscompares++;
            $display("FAIL post_reset_sum got %0h want %0h", err_sum, exp_sum);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        bit rdy;
        longint unsigned held;
        load_const(4, 32'h0001_8000, 32'h0001_0000);
        model(4);
        do_run(4, 0, 1'b0, lat, rdy);
        vectors++;
        if (64'(err_sum) !== 64'h2_0000 || exp_sum !== 64'h2_0000) begin
            miscompares++;
            $display("FAIL b2b_sum got %0h want 20000", err_sum);
        end
        vectors++;
        if (64'(err_max) !== 64'h8000) begin
            miscompares++;
            $display("FAIL b2b_max got %0h want 8000", err_max);
        end
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL b2b_latency got %0d want 2", lat);
        end
        held = 64'(err_sum);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ref_i = $urandom;
            qnt_i = $urandom;
            @(negedge clk);
        end
        in_valid = 1'b0;
        vectors++;
        if (!done || in_ready || 64'(err_sum) !== held) begin
            miscompares++;
            $display("FAIL done_hold got done=%b rdy=%b sum=%0h want 1/0/%0h",
                     done, in_ready, err_sum, held);
        end
    endtask

    task automatic test_gaps;
        int lat;
        bit rdy;
        load_const(4, 32'h0001_8000, 32'h0001_0000);
        do_run(4, 1, 1'b0, lat, rdy);
        vectors++;
        if (64'(err_sum) !== 64'h2_0000 || 64'(err_max) !== 64'h8000) begin
            miscompares++;
            $display("FAIL gap_result got sum=%0h max=%0h want 20000/8000", err_sum, err_max);
        end
        vectors++;
        if (rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_ready_drop got %b want 0", rdy);
        end
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL gap_latency got %0d want 2", lat);
        end
    endtask

    task automatic test_sign_flip;
        int lat;
        bit rdy;
        load_const(1, 32'hFFFF_0000, 32'h0000_0000);
        do_run(1, 0, 1'b0, lat, rdy);
        vectors++;
        if (64'(err_sum) !== 64'h1_0000 || 64'(err_max) !== 64'h1_0000) begin
            miscompares++;
            $display("FAIL sign_flip got sum=%0h max=%0h want 10000/10000", err_sum, err_max);
        end
    endtask

    task automatic test_zero_len;
        int lat;
        bit rdy;
        stim_ref.delete();
        stim_qnt.delete();
        do_run(0, 0, 1'b0, lat, rdy);
        vectors++;
        if (lat !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_len_done got lat=%0d busy=%b want 0/0", lat, busy);
        end
        vectors++;
        if (err_sum !== '0 || err_max !== '0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_len_results got sum=%0h max=%0h ovf=%b want 0/0/0",
                     err_sum, err_max, overflow);
        end
    endtask

    task automatic test_saturation;
        int lat;
        bit rdy;
        load_const(3, 32'h7FFF_FFFF, 32'h8000_0000);
        model(3);
        do_run(3, 0, 1'b1, lat, rdy);
        vectors++;
        if (64'(err_sum) !== 64'h1_FFFF_FFFF || exp_sum !== 64'h1_FFFF_FFFF) begin
            miscompares++;
            $display("FAIL sat_sum got %0h want 1ffffffff", err_sum);
        end
        vectors++;
        if (overflow !== 1'b1 || 64'(err_max) !== 64'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL sat_ovf_max got ovf=%b max=%0h want 1/ffffffff", overflow, err_max);
        end
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL sat_stray_start_latency got %0d want 2", lat);
        end
    endtask

    task automatic test_random;
        int lat;
        bit rdy;
        int n;
        int gap;
        logic [31:0] r;
        for (int run = 0; run < 8; run++) begin
            n = $urandom_range(1, 24);
            gap = $urandom_range(0, 2);
            stim_ref.delete();
            stim_qnt.delete();
            for (int i = 0; i < n; i++) begin
                r = $urandom;
                stim_ref.push_back(r);
                if (run % 2 == 0) stim_qnt.push_back(r ^ 32'($urandom_range(0, 32'hFFFF)));
                else              stim_qnt.push_back($urandom);
            end
            model(n);
            do_run(n, gap, 1'b0, lat, rdy);
            vectors++;
            if (64'(err_sum) !== exp_sum || overflow !== exp_ovf) begin
                miscompares++;
                $display("FAIL rand_sum run=%0d got %0h/%b want %0h/%b",
                         run, err_sum, overflow, exp_sum, exp_ovf);
            end
            vectors++;
            if (64'(err_max) !== exp_max || lat !== 2) begin
                miscompares++;
                $display("FAIL rand_max run=%0d got max=%0h lat=%0d want %0h/2",
                         run, err_max, lat, exp_max);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_sign_flip();
        test_zero_len();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
